// File: rtl/adc_frontend.sv
// ADC acquisition front end: gathers A/B/C/angle into a frame, calibrates
// per-phase offsets over 2^CAL_LOG2 frames, then hands corrected frames to the FOC top.
//
// state | meaning
// CAL   | averaging frames to measure per-phase offsets, no frames issued
// RUN   | offsets valid, corrected frames staged and issued on ready_in
module adc_frontend #(
  parameter int D_WIDTH    = 19,
  parameter int ADC_BITS   = 12,
  parameter int CAL_LOG2   = 4,
  parameter int GAIN_SHIFT = 3
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               adc_valid,
  input  logic [1:0]         adc_ch,
  input  logic [15:0]        adc_data,
  input  logic               cal_start,
  input  logic               ready_in,
  output logic               valid_out,
  output logic [D_WIDTH-1:0] angle_out,
  output logic [D_WIDTH-1:0] currA_out,
  output logic [D_WIDTH-1:0] currB_out,
  output logic [D_WIDTH-1:0] currC_out,
  output logic               cal_done,
  output logic               overrun
);

  localparam int ACC_W = ADC_BITS + CAL_LOG2;
  localparam int CNT_W = CAL_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << CAL_LOG2) - 1);

  typedef enum logic {CAL, RUN} state_t;

  state_t              state_q;
  logic [ADC_BITS-1:0] raw_a_q, raw_b_q, raw_c_q;
  logic [15:0]         raw_ang_q;
  logic [3:0]          mask_q;
  logic [ACC_W-1:0]    acc_a_q, acc_b_q, acc_c_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ADC_BITS-1:0] off_a_q, off_b_q, off_c_q;
  logic [D_WIDTH-1:0]  stg_a_q, stg_b_q, stg_c_q, stg_ang_q;
  logic                pending_q;

  logic [ADC_BITS-1:0] raw_a_d, raw_b_d, raw_c_d;
  logic [15:0]         raw_ang_d;
  logic [3:0]          mask_d;
  logic [ACC_W-1:0]    acc_a_d, acc_b_d, acc_c_d;
  logic                frame_done, issue;

  function automatic logic [D_WIDTH-1:0] correct(input logic [ADC_BITS-1:0] raw,
                                                 input logic [ADC_BITS-1:0] off);
    logic [ADC_BITS:0]  diff;
    logic [D_WIDTH-1:0] ext;
    diff = {1'b0, raw} - {1'b0, off};
    ext  = {{(D_WIDTH-ADC_BITS-1){diff[ADC_BITS]}}, diff};
    return ext << GAIN_SHIFT;
  endfunction

  // Merge the current strobe so a frame can complete on the same edge.
  always_comb begin
    raw_a_d   = raw_a_q;
    raw_b_d   = raw_b_q;
    raw_c_d   = raw_c_q;
    raw_ang_d = raw_ang_q;
    mask_d    = mask_q;
    if (adc_valid) begin
      mask_d = mask_q | (4'b0001 << adc_ch);
      case (adc_ch)
        2'd0:    raw_a_d   = adc_data[ADC_BITS-1:0];
        2'd1:    raw_b_d   = adc_data[ADC_BITS-1:0];
        2'd2:    raw_c_d   = adc_data[ADC_BITS-1:0];
        default: raw_ang_d = adc_data;
      endcase
    end
    frame_done = adc_valid && (mask_d == 4'b1111);
    issue      = pending_q && ready_in;
    acc_a_d    = acc_a_q + ACC_W'(raw_a_d);
    acc_b_d    = acc_b_q + ACC_W'(raw_b_d);
    acc_c_d    = acc_c_q + ACC_W'(raw_c_d);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= CAL;
      raw_a_q   <= '0; raw_b_q <= '0; raw_c_q <= '0; raw_ang_q <= '0;
      mask_q    <= '0;
      acc_a_q   <= '0; acc_b_q <= '0; acc_c_q <= '0;
      cnt_q     <= '0;
      off_a_q   <= '0; off_b_q <= '0; off_c_q <= '0;
      stg_a_q   <= '0; stg_b_q <= '0; stg_c_q <= '0; stg_ang_q <= '0;
      pending_q <= 1'b0;
      valid_out <= 1'b0;
      angle_out <= '0; currA_out <= '0; currB_out <= '0; currC_out <= '0;
      cal_done  <= 1'b0;
      overrun   <= 1'b0;
    end else if (cal_start) begin
      // Offsets survive a recalibration until the new ones are ready.
      state_q   <= CAL;
      mask_q    <= '0;
      acc_a_q   <= '0; acc_b_q <= '0; acc_c_q <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      valid_out <= 1'b0;
      cal_done  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      valid_out <= issue;
      if (issue) begin
        currA_out <= stg_a_q;
        currB_out <= stg_b_q;
        currC_out <= stg_c_q;
        angle_out <= stg_ang_q;
      end
      if (adc_valid) begin
        raw_a_q   <= raw_a_d;
        raw_b_q   <= raw_b_d;
        raw_c_q   <= raw_c_d;
        raw_ang_q <= raw_ang_d;
        mask_q    <= frame_done ? 4'b0000 : mask_d;
      end
      case (state_q)
        CAL: begin
          if (frame_done) begin
            acc_a_q <= acc_a_d;
            acc_b_q <= acc_b_d;
            acc_c_q <= acc_c_d;
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              off_a_q  <= acc_a_d[ACC_W-1:CAL_LOG2];
              off_b_q  <= acc_b_d[ACC_W-1:CAL_LOG2];
              off_c_q  <= acc_c_d[ACC_W-1:CAL_LOG2];
              cal_done <= 1'b1;
              state_q  <= RUN;
            end
          end
        end
        default: begin
          if (frame_done) begin
            stg_a_q   <= correct(raw_a_d, off_a_q);
            stg_b_q   <= correct(raw_b_d, off_b_q);
            stg_c_q   <= correct(raw_c_d, off_c_q);
            stg_ang_q <= D_WIDTH'(raw_ang_d);
            pending_q <= 1'b1;
            if (pending_q && !issue) overrun <= 1'b1;
          end else if (issue) begin
            pending_q <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_frontend.sv
// Directed bench for adc_frontend: calibration, frame issue, overrun,
// repeated channels, recalibration and reset during calibration.
module tb_adc_frontend;

  localparam int DW = 19;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          adc_valid = 1'b0;
  logic [1:0]    adc_ch = '0;
  logic [15:0]   adc_data = '0;
  logic          cal_start = 1'b0;
  logic          ready_in = 1'b0;
  logic          valid_out;
  logic [DW-1:0] angle_out, currA_out, currB_out, currC_out;
  logic          cal_done, overrun;

  int checks = 0;
  int failures = 0;
  int vcount = 0;
  int vbase;

  adc_frontend dut (
    .clk(clk), .rstb(rstb), .adc_valid(adc_valid), .adc_ch(adc_ch),
    .adc_data(adc_data), .cal_start(cal_start), .ready_in(ready_in),
    .valid_out(valid_out), .angle_out(angle_out), .currA_out(currA_out),
    .currB_out(currB_out), .currC_out(currC_out), .cal_done(cal_done),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (valid_out) vcount++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [1:0] ch, input logic [15:0] data);
    @(negedge clk);
    adc_valid = 1'b1; adc_ch = ch; adc_data = data;
    @(posedge clk); #1;
    adc_valid = 1'b0;
  endtask

  task automatic frame(input int a, input int b, input int c, input int ang);
    strobe(2'd0, 16'(a));
    strobe(2'd1, 16'(b));
    strobe(2'd2, 16'(c));
    strobe(2'd3, 16'(ang));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    cycles(2);
    chk("rst_cal_done", 32'(cal_done), 0);
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_currA", 32'(currA_out), 0);
    chk("rst_angle", 32'(angle_out), 0);
    @(negedge clk); rstb = 1'b1;
    ready_in = 1'b1;

    // 1: calibration to 2048
    for (int i = 0; i < 15; i++) frame(2048, 2048, 2048, 16'h1234);
    chk("t1_cal_15", 32'(cal_done), 0);
    frame(2048, 2048, 2048, 16'h1234);
    chk("t1_cal_16", 32'(cal_done), 1);
    cycles(2);
    chk("t1_no_valid", 32'(vcount), 0);

    // 2: first corrected frame, 2-edge latency
    frame(2148, 1948, 2048, 16'hBEEF);
    chk("t2_valid_early", 32'(valid_out), 0);
    cycles(1);
    chk("t2_valid", 32'(valid_out), 1);
    chk("t2_currA", 32'(currA_out), 32'd800);
    chk("t2_currB", 32'(currB_out), 32'h7FCE0);
    chk("t2_currC", 32'(currC_out), 0);
    chk("t2_angle", 32'(angle_out), 32'h0BEEF);
    cycles(1);
    chk("t2_pulse", 32'(valid_out), 0);
    chk("t2_hold", 32'(currA_out), 32'd800);
    chk("t2_count", 32'(vcount), 1);

    // 3: overrun while not ready
    @(negedge clk); ready_in = 1'b0;
    vbase = vcount;
    frame(2148, 1948, 2048, 16'h0001);
    frame(2098, 1998, 2058, 16'h0002);
    cycles(2);
    chk("t3_overrun", 32'(overrun), 1);
    chk("t3_no_valid", 32'(vcount - vbase), 0);
    @(negedge clk); ready_in = 1'b1;
    @(posedge clk); #1;
    chk("t3_valid", 32'(valid_out), 1);
    chk("t3_currA", 32'(currA_out), 32'd400);
    chk("t3_currB", 32'(currB_out), 32'h7FE70);
    chk("t3_currC", 32'(currC_out), 32'd80);
    chk("t3_angle", 32'(angle_out), 32'h2);
    cycles(4);
    chk("t3_single", 32'(vcount - vbase), 1);

    // 4: repeated channel overwrites, frame completes on ch3
    vbase = vcount;
    strobe(2'd0, 16'd2100);
    strobe(2'd0, 16'd2060);
    strobe(2'd1, 16'd2048);
    strobe(2'd2, 16'd2048);
    cycles(2);
    chk("t4_not_done", 32'(vcount - vbase), 0);
    strobe(2'd3, 16'h1111);
    cycles(1);
    chk("t4_valid", 32'(valid_out), 1);
    chk("t4_currA", 32'(currA_out), 32'd96);
    chk("t4_angle", 32'(angle_out), 32'h1111);

    // 5: recalibrate with a pending frame
    @(negedge clk); ready_in = 1'b0;
    frame(2148, 2048, 2048, 16'h0005);
    vbase = vcount;
    @(negedge clk); cal_start = 1'b1;
    @(posedge clk); #1; cal_start = 1'b0;
    chk("t5_cal_done_lo", 32'(cal_done), 0);
    chk("t5_overrun_clr", 32'(overrun), 0);
    @(negedge clk); ready_in = 1'b1;
    cycles(3);
    chk("t5_dropped", 32'(vcount - vbase), 0);
    for (int i = 0; i < 16; i++) frame(1000, 1000, 1000, 0);
    chk("t5_cal_done", 32'(cal_done), 1);
    frame(1010, 990, 1000, 16'h0055);
    cycles(1);
    chk("t5_valid", 32'(valid_out), 1);
    chk("t5_currA", 32'(currA_out), 32'd80);
    chk("t5_currB", 32'(currB_out), 32'h7FFB0);
    chk("t5_currC", 32'(currC_out), 0);

    // 6: truncated mean, reset mid-calibration
    @(negedge clk); cal_start = 1'b1;
    @(posedge clk); #1; cal_start = 1'b0;
    for (int i = 0; i < 8; i++) frame((i % 2 == 0) ? 2047 : 2050, 2048, 2048, 0);
    @(negedge clk); rstb = 1'b0;
    #1;
    chk("t6_rst_currA", 32'(currA_out), 0);
    chk("t6_rst_cal", 32'(cal_done), 0);
    @(negedge clk); rstb = 1'b1;
    for (int i = 0; i < 15; i++) frame((i % 2 == 0) ? 2047 : 2050, 2048, 2048, 0);
    chk("t6_cal_15", 32'(cal_done), 0);
    frame(2050, 2048, 2048, 0);
    chk("t6_cal_16", 32'(cal_done), 1);
    frame(2048, 2049, 2047, 16'hFFFF);
    cycles(1);
    chk("t6_valid", 32'(valid_out), 1);
    chk("t6_currA", 32'(currA_out), 0);
    chk("t6_currB", 32'(currB_out), 32'd8);
    chk("t6_currC", 32'(currC_out), 32'h7FFF8);
    chk("t6_angle", 32'(angle_out), 32'h0FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_frontend.md
Name: adc_frontend

Overview:
- Acquisition stage directly upstream of the FOC top.
- Collects raw phase-current ADC samples (channels 0-2) and the resolver angle (channel 3) from a channel-tagged sample stream.
- Removes per-phase offsets measured during a calibration phase, then scales and sign-extends the currents to D_WIDTH.
- Presents one coherent frame to the FOC top, using the top's valid/ready handshake.

Parameters:
D_WIDTH, 19, width of current/angle outputs (matches FOC top)
ADC_BITS, 12, unsigned width of raw current samples
CAL_LOG2, 4, log2 of calibration frame count (16 frames)
GAIN_SHIFT, 3, left shift applied to offset-corrected current; constraint ADC_BITS+1+GAIN_SHIFT <= D_WIDTH

Ports:
clk  in  1  clock
rstb  in  1  reset; asynchronous, active-low
adc_valid  in  1  sample strobe, one sample per cycle when high
adc_ch  in  2  channel tag: 0=A, 1=B, 2=C, 3=angle
adc_data  in  16  sample; ch0-2 use [ADC_BITS-1:0] unsigned, ch3 uses all 16 bits
cal_start  in  1  one-cycle request to restart calibration
ready_in  in  1  ready level from FOC top
valid_out  out  1  one-cycle frame strobe to FOC top valid
angle_out  out  D_WIDTH  angle, zero-extended
currA_out, currB_out, currC_out  out  D_WIDTH each  signed corrected currents
cal_done  out  1  high while offsets are valid (RUN state)
overrun  out  1  sticky: a pending frame was overwritten

Behaviour:
- Reset values:
  - state=CAL; all outputs 0.
  - Offsets, accumulators, calibration counter, channel mask, pending flag and staging registers all 0.
- Collection:
  - On each edge with adc_valid=1, write adc_data into the collection register for adc_ch and set mask bit adc_ch.
  - A repeated channel within a frame overwrites its value; the mask is unchanged.
- Frame completion:
  - Occurs at the edge where the mask (including the current strobe) becomes 4'b1111.
  - The mask clears at that same edge, so the next strobe starts a new frame.
- Arithmetic, per phase:
  - diff = {1'b0,raw} - {1'b0,offset}, signed ADC_BITS+1 bits.
  - diff << GAIN_SHIFT, sign-extended to D_WIDTH. No saturation is needed by construction.
  - Angle = adc_data[15:0] zero-extended.
- State CAL:
  - At each frame completion, add raw A/B/C to their accumulators (width ADC_BITS+CAL_LOG2) and increment the counter.
  - When the counter reaches 2^CAL_LOG2 (on the completion that makes it so), load offset = acc >> CAL_LOG2 (truncating), set cal_done=1 and go to RUN.
  - No frame is staged or issued in CAL; valid_out stays 0.
- State RUN:
  - At frame completion, write corrected values into the staging registers and set pending=1.
  - If pending was already 1 and no valid is issued at that edge, the old frame is dropped and overrun is set to 1.
- Issue:
  - At each edge, if pending=1 and ready_in=1: load staging into the outputs, valid_out<=1, pending<=0. Otherwise valid_out<=0.
  - Latency: valid_out is high in the cycle after the edge following the completing strobe, i.e. 2 edges, provided ready_in=1.
  - Outputs hold their value between strobes.
- Simultaneous frame completion and issue at the same edge:
  - Issue the old staged frame.
  - The new frame enters staging and pending remains 1; no overrun.
- cal_start:
  - Takes effect in any state at the next edge.
  - Clears accumulators, counter, mask, pending, cal_done and overrun; state goes to CAL.
  - Offsets are retained until the new calibration completes.
  - cal_start concurrent with a strobe: the strobe is discarded.
- rstb low mid-frame or mid-calibration: everything returns immediately to reset values.

Test Plan:
1. Reset, then 16 frames with A=B=C=2048 and angle=0x1234 -> cal_done rises after the edge sampling the 16th frame's last strobe; offsets=2048; valid_out stays 0 throughout.
2. RUN, ready_in=1, frame A=2148, B=1948, C=2048, angle=0xBEEF -> 2 edges later valid_out pulses once with currA_out=800, currB_out=-800 (19'h7FCE0), currC_out=0, angle_out=19'h0BEEF.
3. ready_in=0, two complete frames in sequence -> overrun=1, no valid; ready_in then high -> a single valid_out carrying the second frame's values.
4. Frame sent as ch0, ch0 (value 2100 then 2060), ch1, ch2, ch3 -> one frame with currA_out=96; completes on the ch3 strobe.
5. cal_start asserted in RUN with a pending frame -> pending dropped, no valid, cal_done=0; 16 frames of 1000 -> new offsets=1000 and cal_done=1.
6. Calibration with A alternating 2047/2050 over 16 frames -> offset=2048 (truncated mean of 32776/16=2048.5); rstb pulsed after frame 8 -> counter restarts and cal_done is only reached after 16 new frames.
